i2s_dac_serializer: RTL and testbench
=====================================

// Module: i2s_dac_serializer
// PURPOSE
//  Downstream of the fast-to-slow sample CDC: takes the registered parallel L/R
//  audio words and serializes them to the audio codec DAC in I2S format.
//  Generates BCLK, LRCK and DACDAT from one system clock via an integer divider.
//  Latches both channel words together once per frame and pulses a request so
//  the upstream stage can present the next sample pair.
// PARAMETERS
//  WIDTH      16  sample width per channel (bits)
//  SLOT_BITS  32  BCLK periods per channel slot; must be >= WIDTH+1
//  BCLK_DIV   4   clk cycles per BCLK half-period; must be >= 1
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  reset_n     in   1      asynchronous, active-low reset
//  enable      in   1      1 = run frames; 0 = stop at end of current frame
//  left_in     in   WIDTH  left sample, two's complement
//  right_in    in   WIDTH  right sample, two's complement
//  sample_req  out  1      1-clk pulse when left_in/right_in are latched
//  busy        out  1      1 while in RUN
//  bclk        out  1      codec bit clock, period 2*BCLK_DIV clk
//  lrck        out  1      0 = left slot, 1 = right slot
//  dacdat      out  1      serial data, MSB first, 1-BCLK I2S delay
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE; bclk, lrck, dacdat,
//    sample_req, busy all 0; div_cnt, bit_cnt, shadow L/R regs all 0.
//  - States: IDLE, RUN. IDLE -> RUN on any clk edge with enable=1: div_cnt=0,
//    bit_cnt=0, bclk=0, lrck=0, shadows <= left_in/right_in, sample_req=1.
//  - RUN: div_cnt counts 0..BCLK_DIV-1; at terminal count it wraps and bclk
//    toggles. bclk rising = codec sample point; all lrck/dacdat/bit_cnt updates
//    occur only on bclk falling (the clk edge where bclk goes 1->0).
//  - bit_cnt 0..2*SLOT_BITS-1, +1 per bclk falling edge, wraps to 0.
//  - lrck = (bit_cnt >= SLOT_BITS), registered with bit_cnt.
//  - dacdat for bit_cnt=k: k in 1..WIDTH -> left_shadow[WIDTH-k];
//    k in SLOT_BITS+1..SLOT_BITS+WIDTH -> right_shadow[SLOT_BITS+WIDTH-k];
//    all other k (incl. 0, SLOT_BITS, padding) -> 0.
//  - Frame end (falling edge where bit_cnt wraps to 0): if enable=1, reload
//    both shadows from inputs and pulse sample_req (exactly 1 clk); if enable=0,
//    go IDLE with all outputs 0, no sample_req.
//  - enable deasserted mid-frame: frame completes unchanged; re-asserted before
//    frame end: no effect (continuous run).
//  - left_in/right_in ignored except at load instants; mid-frame changes never
//    affect the frame in flight. L/R always from the same load (no tearing).
//  - Frame length = 2*SLOT_BITS*2*BCLK_DIV clk (defaults: 512 clk);
//    sample_req period equals frame length while enabled.
//  - Latency: load -> left MSB on dacdat = 2*BCLK_DIV clk (first bclk fall).
//  - busy = 1 exactly while state=RUN.
// TESTING
//  1. Hold reset_n=0, toggle clk/inputs -> all outputs 0; assert reset_n low
//     asynchronously between clk edges mid-frame -> outputs 0 immediately.
//  2. Defaults, enable=1, L=16'hA5C3, R=16'h0001 -> bclk period 8 clk, lrck
//     toggles every 256 clk; bits sampled on bclk rise: left slot 0,A5C3,15x0;
//     right slot 0,0001,15x0.
//  3. Change L to 16'h7FFF at bit_cnt=5 -> current frame still A5C3; next
//     frame 7FFF; sample_req pulses once per 512 clk, width 1 clk.
//  4. Drop enable at bit_cnt=40 -> frame completes (right word sent), then IDLE,
//    busy=0, no further sample_req; re-enable -> new frame starts next clk.
//  5. Pulse enable low for 10 clk mid-frame -> no interruption, frames back-to-back.
//  6. WIDTH=24, SLOT_BITS=32, BCLK_DIV=2, L=24'h800001 -> MSB at bit 1, LSB at
//    bit 24, bits 25..31 zero, bclk period 4 clk.

Source files
------------

// File: rtl/i2s_dac_serializer.sv
// I2S transmitter: divides clk down to bclk, frames lrck and shifts the latched
// left/right sample pair out on dacdat, MSB first with the one-bclk I2S delay.
module i2s_dac_serializer #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    output logic             sample_req,
    output logic             busy,
    output logic             bclk,
    output logic             lrck,
    output logic             dacdat
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW = $clog2(FRAME_BITS);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] left_sh;
    logic [WIDTH-1:0] right_sh;

    logic          div_tc;
    logic          fall;
    logic          frame_end;
    logic [CW-1:0] bit_nxt;
    logic          data_nxt;

    // Everything registered on a bclk falling edge is derived from the slot
    // position it is about to enter, so the codec sees it settled at the rise.
    always_comb begin
        div_tc    = (div_cnt == DW'(BCLK_DIV - 1));
        fall      = div_tc && bclk;
        frame_end = (bit_cnt == CW'(FRAME_BITS - 1));
        bit_nxt   = frame_end ? '0 : bit_cnt + CW'(1);
        data_nxt  = 1'b0;
        if (bit_nxt >= CW'(1) && bit_nxt <= CW'(WIDTH))
            data_nxt = left_sh[IW'(WIDTH - int'(bit_nxt))];
        else if (bit_nxt >= CW'(SLOT_BITS + 1) && bit_nxt <= CW'(SLOT_BITS + WIDTH))
            data_nxt = right_sh[IW'(SLOT_BITS + WIDTH - int'(bit_nxt))];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shadow words are plain flops, not RAM, so resetting them is free and keeps dacdat defined.
            state      <= IDLE;
            busy       <= 1'b0;
            sample_req <= 1'b0;
            bclk       <= 1'b0;
            lrck       <= 1'b0;
            dacdat     <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            left_sh    <= '0;
            right_sh   <= '0;
        end else begin
            sample_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        bclk       <= 1'b0;
                        lrck       <= 1'b0;
                        dacdat     <= 1'b0;
                        left_sh    <= left_in;
                        right_sh   <= right_in;
                        sample_req <= 1'b1;
                    end
                end
                RUN: begin
                    div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
                    if (div_tc)
                        bclk <= ~bclk;
                    if (fall) begin
                        if (frame_end && !enable) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                            lrck    <= 1'b0;
                            dacdat  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_nxt;
                            lrck    <= (bit_nxt >= CW'(SLOT_BITS));
                            dacdat  <= data_nxt;
                            // Both words reload together so L/R always come from one sample pair.
                            if (frame_end) begin
                                left_sh    <= left_in;
                                right_sh   <= right_in;
                                sample_req <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench for i2s_dac_serializer: default instance (16/32/4) plus a
// 24-bit, BCLK_DIV=2 instance for the wide-word case.
module tb_i2s_dac_serializer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en_a, en_b;
    logic [15:0] left_a, right_a;
    logic [23:0] left_b, right_b;
    logic        a_req, a_busy, a_bclk, a_lrck, a_dat;
    logic        b_req, b_busy, b_bclk, b_lrck, b_dat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic sel = 1'b0;
    logic cap_req, cap_bclk, cap_lrck, cap_dat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cap_req  = sel ? b_req  : a_req;
        cap_bclk = sel ? b_bclk : a_bclk;
        cap_lrck = sel ? b_lrck : a_lrck;
        cap_dat  = sel ? b_dat  : a_dat;
    end

    i2s_dac_serializer #(.WIDTH(16), .SLOT_BITS(32), .BCLK_DIV(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .left_in(left_a), .right_in(right_a),
        .sample_req(a_req), .busy(a_busy), .bclk(a_bclk), .lrck(a_lrck), .dacdat(a_dat));

    i2s_dac_serializer #(.WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .left_in(left_b), .right_in(right_b),
        .sample_req(b_req), .busy(b_busy), .bclk(b_bclk), .lrck(b_lrck), .dacdat(b_dat));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_req(input string tag, output int t);
        int n = 0;
        t = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cap_req && n < 700);
        if (!cap_req) timeout(tag);
        t = cyc;
    endtask

    // Records dacdat/lrck at the 64 bclk rises of one frame (bit 63 of the
    // result = bit_cnt 0); optionally changes left_a/en_a at rise chg_bit.
    task automatic capture(input int chg_bit, input logic [15:0] chg_l, input logic chg_en,
                           output logic [63:0] dat, output logic [63:0] lr, output int per);
        logic prev;
        int r0 = 0;
        dat = '0;
        lr  = '0;
        per = 0;
        for (int i = 0; i < 64; i++) begin
            int n = 0;
            do begin
                prev = cap_bclk;
                @(negedge clk);
                n++;
            end while (!(!prev && cap_bclk) && n < 40);
            if (n >= 40) begin
                timeout("bclk_rise");
                return;
            end
            dat[63-i] = cap_dat;
            lr[63-i]  = cap_lrck;
            if (i == 0) r0 = cyc;
            if (i == 1) per = cyc - r0;
            if (i == chg_bit) begin
                left_a = chg_l;
                en_a   = chg_en;
            end
        end
    endtask

    localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

    initial begin
        logic [63:0] dat, lr;
        int per, t0, t1, t2, t3, t4, nreq;

        // Reset held: inputs toggling, outputs stay 0.
        reset_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1;
        left_a = 16'hA5C3; right_a = 16'h0001;
        left_b = 24'h800001; right_b = 24'h123456;
        repeat (3) begin
            @(negedge clk);
            en_a = ~en_a; en_b = ~en_b; left_a = ~left_a;
        end
        @(negedge clk);
        check("reset_a_outputs", {a_req, a_busy, a_bclk, a_lrck, a_dat}, 5'b0);
        check("reset_b_outputs", {b_req, b_busy, b_bclk, b_lrck, b_dat}, 5'b0);

        // Default instance: A5C3 / 0001.
        en_a = 1'b0; en_b = 1'b0;
        left_a = 16'hA5C3; right_a = 16'h0001;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", a_busy, 1'b0);
        en_a = 1'b1;
        wait_req("first_req", t0);
        check("run_busy", a_busy, 1'b1);
        capture(-1, 16'h0, 1'b1, dat, lr, per);
        check("frame1_data", dat, {1'b0, 16'hA5C3, 15'b0, 1'b0, 16'h0001, 15'b0});
        check("frame1_lrck", lr, LR_EXP);
        check("bclk_period", per, 8);

        // Left input changes at bit 5: frame in flight keeps A5C3.
        wait_req("req2", t1);
        check("req_period_1", t1 - t0, 512);
        @(negedge clk);
        check("req_width", a_req, 1'b0);
        capture(5, 16'h7FFF, 1'b1, dat, lr, per);
        check("frame2_data", dat, {1'b0, 16'hA5C3, 15'b0, 1'b0, 16'h0001, 15'b0});

        // Enable dropped at bit 40: frame completes with the new left word.
        wait_req("req3", t2);
        check("req_period_2", t2 - t1, 512);
        capture(40, 16'h7FFF, 1'b0, dat, lr, per);
        check("frame3_data", dat, {1'b0, 16'h7FFF, 15'b0, 1'b0, 16'h0001, 15'b0});
        check("frame3_lrck", lr, LR_EXP);
        repeat (6) @(negedge clk);
        check("stopped_outputs", {a_req, a_busy, a_bclk, a_lrck, a_dat}, 5'b0);
        nreq = 0;
        repeat (600) begin
            @(negedge clk);
            if (a_req) nreq++;
        end
        check("no_req_when_idle", nreq, 0);

        // Re-enable: new frame starts at the next clk edge.
        en_a = 1'b1;
        @(negedge clk);
        check("restart_req_busy", {a_req, a_busy}, 2'b11);
        t3 = cyc;

        // Short enable glitch mid-frame: no interruption.
        repeat (100) @(negedge clk);
        en_a = 1'b0;
        repeat (10) @(negedge clk);
        en_a = 1'b1;
        check("glitch_busy", a_busy, 1'b1);
        wait_req("req_glitch", t4);
        check("glitch_req_period", t4 - t3, 512);

        // Wide instance: 24-bit word, bclk period 4.
        sel  = 1'b1;
        en_b = 1'b1;
        wait_req("b_req", t0);
        capture(-1, 16'h7FFF, 1'b1, dat, lr, per);
        check("b_frame_data", dat, {1'b0, 24'h800001, 7'b0, 1'b0, 24'h123456, 7'b0});
        check("b_frame_lrck", lr, LR_EXP);
        check("b_bclk_period", per, 4);
        wait_req("b_req2", t1);
        check("b_req_period", t1 - t0, 256);

        // Asynchronous reset between clock edges while both run.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_a", {a_req, a_busy, a_bclk, a_lrck, a_dat}, 5'b0);
        check("async_reset_b", {b_req, b_busy, b_bclk, b_lrck, b_dat}, 5'b0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
